// File: rtl/exc_ctrl.sv
// Exception/ERET commit controller: captures a WB event, strobes CP0, redirects IF, drains.
// Optional interrupt recognition is enabled by defining EXC_CTRL_INT_EN.
module exc_ctrl #(
    parameter logic [31:0] EX_ENTRY     = 32'hbfc00380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic        wb_ex,
    input  logic [4:0]  wb_excode,
    input  logic        wb_eret,
    input  logic [31:0] wb_pc,
    input  logic        wb_bd,
    input  logic        c0_status_ie,
    input  logic        c0_status_exl,
    input  logic [7:0]  c0_status_im,
    input  logic [7:0]  c0_cause_ip,
    input  logic [31:0] c0_epc,
    output logic        cp0_ex,
    output logic [4:0]  cp0_excode,
    output logic [31:0] cp0_pc,
    output logic        cp0_bd,
    output logic        cp0_eret,
    output logic        flush,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        REDIRECT,
        DRAIN
    } state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(FLUSH_CYCLES - 1);

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [4:0]  cap_excode;
    logic [31:0] cap_pc;
    logic        cap_bd;
    logic        cap_eret;
    logic [31:0] rpc;
    logic        int_pending;
    logic        event_hit;
    logic        take;
    logic        in_commit;

`ifdef EXC_CTRL_INT_EN
    assign int_pending = c0_status_ie & ~c0_status_exl
                       & |(c0_status_im & c0_cause_ip);
`else
    logic unused_int;
    assign unused_int  = ^{c0_status_ie, c0_status_exl,
                           c0_status_im, c0_cause_ip};
    assign int_pending = 1'b0;
`endif

    assign event_hit = wb_valid & (int_pending | wb_ex | wb_eret);
    assign take      = (state == IDLE) & event_hit;
    assign in_commit = (state == COMMIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (event_hit) state_nx = COMMIT;
            end
            COMMIT: begin
                state_nx = REDIRECT;
            end
            REDIRECT: begin
                if (redirect_ready) state_nx = DRAIN;
            end
            DRAIN: begin
                if (cnt == 4'd0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Interrupt outranks a synchronous exception, which outranks ERET.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cap_excode <= '0;
            cap_pc     <= '0;
            cap_bd     <= 1'b0;
            cap_eret   <= 1'b0;
        end else if (take) begin
            cap_pc <= wb_pc;
            cap_bd <= wb_bd;
            if (int_pending) begin
                cap_excode <= 5'h00;
                cap_eret   <= 1'b0;
            end else if (wb_ex) begin
                cap_excode <= wb_excode;
                cap_eret   <= 1'b0;
            end else begin
                cap_excode <= 5'h00;
                cap_eret   <= 1'b1;
            end
        end
    end

    // ERET target is EPC as CP0 presents it during the commit cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rpc <= '0;
        end else if (take && (int_pending || wb_ex)) begin
            rpc <= EX_ENTRY;
        end else if (in_commit && cap_eret) begin
            rpc <= c0_epc;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (state == REDIRECT && redirect_ready) begin
            cnt <= DRAIN_LAST;
        end else if (state == DRAIN && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign wb_ready       = (state == IDLE);
    assign flush          = (state != IDLE);
    assign redirect_valid = (state == REDIRECT);
    assign redirect_pc    = rpc;
    assign cp0_ex         = in_commit & ~cap_eret;
    assign cp0_eret       = in_commit & cap_eret;
    assign cp0_excode     = in_commit ? cap_excode : 5'h00;
    assign cp0_pc         = in_commit ? cap_pc : 32'h0;
    assign cp0_bd         = in_commit & cap_bd;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl; follows EXC_CTRL_INT_EN like the design.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_ex;
    logic [4:0]  wb_excode;
    logic        wb_eret;
    logic [31:0] wb_pc;
    logic        wb_bd;
    logic        c0_status_ie;
    logic        c0_status_exl;
    logic [7:0]  c0_status_im;
    logic [7:0]  c0_cause_ip;
    logic [31:0] c0_epc;
    logic        cp0_ex;
    logic [4:0]  cp0_excode;
    logic [31:0] cp0_pc;
    logic        cp0_bd;
    logic        cp0_eret;
    logic        flush;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;

    int n_chk  = 0;
    int n_pass = 0;
    int ex_cnt = 0;
    int er_cnt = 0;

`ifdef EXC_CTRL_INT_EN
    localparam bit INT_ON = 1'b1;
`else
    localparam bit INT_ON = 1'b0;
`endif

    exc_ctrl dut (
        .clk(clk), .resetn(resetn),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_ex(wb_ex), .wb_excode(wb_excode),
        .wb_eret(wb_eret), .wb_pc(wb_pc), .wb_bd(wb_bd),
        .c0_status_ie(c0_status_ie), .c0_status_exl(c0_status_exl),
        .c0_status_im(c0_status_im), .c0_cause_ip(c0_cause_ip),
        .c0_epc(c0_epc),
        .cp0_ex(cp0_ex), .cp0_excode(cp0_excode),
        .cp0_pc(cp0_pc), .cp0_bd(cp0_bd), .cp0_eret(cp0_eret),
        .flush(flush), .redirect_valid(redirect_valid),
        .redirect_ready(redirect_ready), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cp0_ex) ex_cnt++;
        if (cp0_eret) er_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; wb_valid = 1'b0; wb_ex = 1'b0;
        wb_excode = '0; wb_eret = 1'b0; wb_pc = '0; wb_bd = 1'b0;
        c0_status_ie = 1'b0; c0_status_exl = 1'b0;
        c0_status_im = '0; c0_cause_ip = '0; c0_epc = '0;
        redirect_ready = 1'b0;

        #3;
        check("rst_cp0_ex", cp0_ex, 0);
        check("rst_flush", flush, 0);
        check("rst_rvalid", redirect_valid, 0);
        check("rst_rpc", redirect_pc, 0);
        tick(); tick();
        resetn = 1'b1;
        redirect_ready = 1'b1;
        tick();
        check("rel_wb_ready", wb_ready, 1);
        check("idle_ready_ignored_flush", flush, 0);
        check("idle_ready_ignored_rvalid", redirect_valid, 0);
        check("rel_excode", cp0_excode, 0);
        check("rel_pc", cp0_pc, 0);

        // interrupt only
        c0_status_ie = 1'b1; c0_status_exl = 1'b0;
        c0_status_im = 8'h80; c0_cause_ip = 8'h80;
        wb_valid = 1'b1; wb_pc = 32'hbfc00100;
        tick();
        wb_valid = 1'b0;
        if (INT_ON) begin
            check("int_cp0_ex", cp0_ex, 1);
            check("int_excode", cp0_excode, 5'h00);
            check("int_pc", cp0_pc, 32'hbfc00100);
            check("int_rpc", redirect_pc, 32'hbfc00380);
            check("int_wb_ready", wb_ready, 0);
            tick();
            check("int_redir_rvalid", redirect_valid, 1);
            check("int_redir_cp0_ex", cp0_ex, 0);
            tick();
            check("int_drain_rvalid", redirect_valid, 0);
            check("int_drain_flush", flush, 1);
            tick();
            check("int_drain2_flush", flush, 1);
            tick();
            check("int_idle_flush", flush, 0);
        end else begin
            check("noint_cp0_ex", cp0_ex, 0);
            check("noint_flush", flush, 0);
            check("noint_wb_ready", wb_ready, 1);
        end

        // exception + eret with interrupt still pending
        wb_valid = 1'b1; wb_ex = 1'b1; wb_excode = 5'h04;
        wb_bd = 1'b1; wb_eret = 1'b1; wb_pc = 32'hbfc00200;
        tick();
        wb_valid = 1'b0; wb_ex = 1'b0; wb_eret = 1'b0; wb_bd = 1'b0;
        c0_status_ie = 1'b0;
        check("prio_cp0_ex", cp0_ex, 1);
        check("prio_cp0_eret", cp0_eret, 0);
        check("prio_excode", cp0_excode, INT_ON ? 5'h00 : 5'h04);
        check("prio_bd", cp0_bd, 1);
        check("prio_pc", cp0_pc, 32'hbfc00200);
        tick();
        check("prio_rpc", redirect_pc, 32'hbfc00380);
        check("prio_strobe_gone", cp0_ex, 0);
        tick(); tick(); tick();
        check("prio_idle", wb_ready, 1);

        // ERET with a stalled redirect
        redirect_ready = 1'b0;
        wb_valid = 1'b1; wb_eret = 1'b1; wb_pc = 32'hbfc00300;
        c0_epc = 32'hbfc01234;
        tick();
        wb_valid = 1'b0; wb_eret = 1'b0;
        check("eret_strobe", cp0_eret, 1);
        check("eret_no_ex", cp0_ex, 0);
        tick();
        c0_epc = 32'h0;
        wb_valid = 1'b1; wb_ex = 1'b1; wb_excode = 5'h0c;
        check("eret_strobe_gone", cp0_eret, 0);
        check("eret_rpc", redirect_pc, 32'hbfc01234);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_rvalid", redirect_valid, 1);
            check("stall_flush", flush, 1);
            check("stall_rpc", redirect_pc, 32'hbfc01234);
            check("stall_wb_ready", wb_ready, 0);
        end
        wb_valid = 1'b0; wb_ex = 1'b0;
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        check("stall_drain_rvalid", redirect_valid, 0);
        check("stall_drain_flush", flush, 1);
        tick();
        check("stall_drain2_flush", flush, 1);
        tick();
        check("stall_idle_flush", flush, 0);
        check("stall_idle_ready", wb_ready, 1);
        check("ex_strobes", ex_cnt, INT_ON ? 2 : 1);
        check("eret_strobes", er_cnt, 1);

        // reset in REDIRECT
        wb_valid = 1'b1; wb_ex = 1'b1; wb_excode = 5'h08;
        wb_pc = 32'hbfc00400;
        tick();
        wb_valid = 1'b0; wb_ex = 1'b0;
        check("rst_seq_cp0_ex", cp0_ex, 1);
        tick();
        check("rst_seq_rvalid", redirect_valid, 1);
        resetn = 1'b0;
        #1;
        check("mid_rst_rvalid", redirect_valid, 0);
        check("mid_rst_flush", flush, 0);
        check("mid_rst_rpc", redirect_pc, 0);
        check("mid_rst_cp0_ex", cp0_ex, 0);
        check("mid_rst_cp0_pc", cp0_pc, 0);
        tick(); tick();
        resetn = 1'b1;
        tick();
        check("post_rst_ready", wb_ready, 1);
        check("post_rst_flush", flush, 0);
        check("post_rst_cp0_ex", cp0_ex, 0);
        check("post_rst_strobes", ex_cnt, INT_ON ? 3 : 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 The block SHALL have parameter EX_ENTRY, default 32'hbfc00380, meaning the exception handler redirect address.
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 2, legal range 1..15, meaning the post-redirect drain length in cycles.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port wb_valid  input  1  a WB-stage instruction is present.
REQ-006 The block SHALL have port wb_ready  output  1  the block can accept a WB event this cycle.
REQ-007 The block SHALL have port wb_ex  input  1  the WB instruction carries a synchronous exception.
REQ-008 The block SHALL have port wb_excode  input  5  exception code of the WB instruction.
REQ-009 The block SHALL have port wb_eret  input  1  the WB instruction is ERET.
REQ-010 The block SHALL have port wb_pc  input  32  PC of the WB instruction.
REQ-011 The block SHALL have port wb_bd  input  1  the WB instruction is in a delay slot.
REQ-012 The block SHALL have port c0_status_ie  input  1  CP0 Status.IE.
REQ-013 The block SHALL have port c0_status_exl  input  1  CP0 Status.EXL.
REQ-014 The block SHALL have port c0_status_im  input  8  CP0 Status.IM.
REQ-015 The block SHALL have port c0_cause_ip  input  8  CP0 Cause.IP.
REQ-016 The block SHALL have port c0_epc  input  32  CP0 EPC.
REQ-017 The block SHALL have port cp0_ex  output  1  one-cycle exception commit strobe to CP0.
REQ-018 The block SHALL have port cp0_excode  output  5  excode committed with cp0_ex.
REQ-019 The block SHALL have port cp0_pc  output  32  PC committed with cp0_ex.
REQ-020 The block SHALL have port cp0_bd  output  1  BD committed with cp0_ex.
REQ-021 The block SHALL have port cp0_eret  output  1  one-cycle ERET commit strobe to CP0.
REQ-022 The block SHALL have port flush  output  1  squash all pipeline stages.
REQ-023 The block SHALL have port redirect_valid  output  1  redirect_pc is valid for IF.
REQ-024 The block SHALL have port redirect_ready  input  1  IF accepts the redirect.
REQ-025 The block SHALL have port redirect_pc  output  32  fetch target after flush.

Function
REQ-026 int_pending SHALL be c0_status_ie & ~c0_status_exl & |(c0_status_im & c0_cause_ip), combinational.
REQ-027 The FSM SHALL have states IDLE, COMMIT, REDIRECT, DRAIN; wb_ready SHALL be 1 only in IDLE.
REQ-028 In IDLE, an event (wb_valid & (int_pending | wb_ex | wb_eret)) SHALL register excode/pc/bd/kind and move to COMMIT next cycle; otherwise it SHALL stay in IDLE.
REQ-029 Event priority SHALL be interrupt (excode 5'h00) > wb_ex (wb_excode) > wb_eret.
REQ-030 In COMMIT, exactly one of cp0_ex/cp0_eret SHALL be high for exactly that one cycle, with cp0_excode/cp0_pc/cp0_bd from the captured values; the FSM SHALL then move to REDIRECT.
REQ-031 redirect_pc SHALL be EX_ENTRY for exception/interrupt, or c0_epc sampled during COMMIT for ERET, and SHALL be held stable in REDIRECT.
REQ-032 In REDIRECT, redirect_valid SHALL be 1 until the cycle where redirect_ready=1, then the FSM SHALL move to DRAIN; redirect_ready in any other state SHALL be ignored.
REQ-033 DRAIN SHALL last exactly FLUSH_CYCLES cycles via a 4-bit down counter, then return to IDLE.
REQ-034 flush SHALL be 1 in COMMIT, REDIRECT and DRAIN, and 0 in IDLE.
REQ-035 Events presented while not IDLE SHALL not be captured (wb_ready=0); no event SHALL be lost or committed twice.
REQ-036 All outputs SHALL be registered or decoded purely from state/captured registers; no combinational path SHALL run from wb_* to cp0_* or redirect_*.

Reset
REQ-037 resetn=0 SHALL immediately force state IDLE, counter 0, captured registers 0, and outputs cp0_ex=0, cp0_eret=0, flush=0, redirect_valid=0, redirect_pc=0, cp0_excode=0, cp0_pc=0, cp0_bd=0, wb_ready=1 after release.
REQ-038 Reset asserted mid-sequence SHALL abandon it with no partial strobe.

Configuration
REQ-039 Macro EXC_CTRL_INT_EN defined SHALL enable interrupt recognition per REQ-026; undefined SHALL force int_pending=0, making only wb_ex/wb_eret events.

Verification
REQ-040 ie=1, exl=0, im=8'h80, ip=8'h80, wb_valid=1, wb_pc=32'hbfc00100 -> COMMIT: cp0_ex=1, excode=0, cp0_pc=32'hbfc00100; redirect_pc=32'hbfc00380.
REQ-041 wb_ex=1, wb_excode=5'h04, wb_bd=1, and interrupt pending under EXC_CTRL_INT_EN -> excode 5'h00 committed; without the macro -> excode 5'h04, cp0_bd=1.
REQ-042 wb_eret=1, c0_epc=32'hbfc01234 -> cp0_eret for 1 cycle, redirect_pc=32'hbfc01234.
REQ-043 redirect_ready held 0 for 5 cycles -> redirect_valid and flush stay 1, redirect_pc stable; then DRAIN=2 cycles, IDLE.
REQ-044 resetn pulsed low in REDIRECT -> all outputs 0 immediately, wb_ready=1 after release, no cp0 strobe.
